mac_accum_6bit: RTL and testbench
=================================

// Module: mac_accum_6bit
// PURPOSE
//  Sequential multiply-accumulate controller that sits directly around the 6x6 signed array multiplier.
//  Accepts a stream of signed 6-bit operand pairs over a valid/ready handshake and registers them onto the multiplier inputs.
//  Sign-extends each 12-bit signed product and accumulates N_TERMS of them.
//  Presents the saturated sum downstream over a valid/ready handshake.
// PARAMETERS
//  N_TERMS  4   products per accumulation frame (>=1)
//  ACC_W    16  accumulator/result width in bits, signed two's complement (>=12)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a_in/b_in hold a valid operand pair
//  in_ready   out  1      block can accept an operand pair this cycle
//  a_in       in   6      signed multiplicand
//  b_in       in   6      signed multiplier
//  mult_a     out  6      registered operand to multiplier input a
//  mult_b     out  6      registered operand to multiplier input b
//  mult_p     in   12     signed product returned by multiplier (combinational from mult_a/mult_b)
//  out_valid  out  1      acc_out holds a completed frame sum
//  out_ready  in   1      downstream accepts acc_out this cycle
//  acc_out    out  ACC_W  signed frame sum (saturated)
//  ovf        out  1      sticky: saturation occurred in the current frame
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - state=LOAD; mult_a, mult_b, acc_out, count, ovf = 0; out_valid = 0.
//   - Applies regardless of state; a partial frame is discarded.
//  FSM:
//   - LOAD: in_ready=1. On in_valid&in_ready, latch a_in->mult_a, b_in->mult_b and go to MUL.
//     Otherwise stay in LOAD.
//   - MUL: in_ready=0. acc_next = acc + sext(mult_p, ACC_W), saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     - If saturation occurs, set ovf=1.
//     - Increment count. If count reaches N_TERMS, go to OUT and clear count; else go to LOAD.
//   - OUT: out_valid=1, in_ready=0; acc_out and ovf are held stable.
//     - On out_ready, clear acc and ovf to 0 and go to LOAD.
//     - The next operand can be accepted on the following cycle.
//  Timing:
//   - Throughput: 1 term per 2 cycles.
//   - Last operand accepted at edge t -> out_valid=1 after edge t+1.
//  Data handling:
//   - acc_out is the accumulator register itself; it is visible but not valid outside OUT.
//   - mult_p is treated as a 12-bit two's-complement value, range -992..1024.
//  Handshake and boundary rules:
//   - No combinational path from out_ready to in_ready.
//     in_valid is ignored in MUL/OUT, and a_in/b_in are not sampled there.
//   - N_TERMS=1: LOAD->MUL->OUT every frame.
//   - Saturation is clamped per add; later terms can move the sum back off the rail, but ovf stays 1.
//   - rst and out_ready asserted together: rst wins.
// TESTING
//  - Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, acc_out=0, ovf=0, mult_a=mult_b=0.
//  - Frame N_TERMS=4, ACC_W=16, pairs (3,5),(-2,7),(31,31),(-32,-32), out_ready=1
//    -> acc_out=1986 (16'h07C2), ovf=0, out_valid exactly 1 cycle.
//  - Saturation ACC_W=12, N_TERMS=2, pairs (-32,-32),(-32,-32) -> acc_out=2047, ovf=1;
//    pairs (-32,31),(-32,31),(-32,31) with N_TERMS=3 -> -2048, ovf=1.
//  - Backpressure: out_ready=0 for 5 cycles after frame done
//    -> out_valid, acc_out, ovf stable, in_ready=0 throughout;
//    release -> acc=0, LOAD next cycle.
//  - Reset mid-frame: after 2 of 4 terms, pulse rst
//    -> next 4-term frame (1,1)x4 yields acc_out=4, not contaminated.
//  - Latency/timing: in_valid held high continuously -> in_ready toggles 1,0 per term;
//    out_valid rises the cycle after the 4th MUL.

Source files
------------

// File: rtl/mac_accum_6bit.sv
// Multiply-accumulate controller around an external 6x6 signed multiplier.
// Accepts operand pairs, sums N_TERMS saturated products, and holds the frame sum until it is taken downstream.
module mac_accum_6bit #(
   parameter int unsigned N_TERMS = 4,
   parameter int unsigned ACC_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       a_in,
   input  logic [5:0]       b_in,
   output logic [5:0]       mult_a,
   output logic [5:0]       mult_b,
   input  logic [11:0]      mult_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam int unsigned CNT_W = (N_TERMS < 2) ? 1 : $clog2(N_TERMS);

   typedef enum logic [1:0] {
      S_LOAD,
      S_MUL,
      S_OUT
   } state_e;

   state_e             state_q, state_d;
   logic [5:0]         mult_a_q, mult_a_d;
   logic [5:0]         mult_b_q, mult_b_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;

   // One guard bit: overflow shows as disagreement between the top two bits.
   logic [ACC_W:0]     sum;
   logic               sat;
   logic [ACC_W-1:0]   sat_val;

   always_comb begin
      sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - 12){mult_p[11]}}, mult_p};
      sat     = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
   end

   always_comb begin
      state_d  = state_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      acc_d    = acc_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               mult_a_d = a_in;
               mult_b_d = b_in;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            if (sat) begin
               acc_d = sat_val;
               ovf_d = 1'b1;
            end else begin
               acc_d = sum[ACC_W-1:0];
            end
            if (count_q == CNT_W'(N_TERMS - 1)) begin
               count_d = '0;
               state_d = S_OUT;
            end else begin
               count_d = count_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_LOAD;
         mult_a_q <= '0;
         mult_b_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mult_a_q <= mult_a_d;
         mult_b_q <= mult_b_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = (state_q == S_OUT);
   assign mult_a    = mult_a_q;
   assign mult_b    = mult_b_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accum_6bit.sv
// Bench for mac_accum_6bit: three parameterisations sharing one clock, each with a behavioural multiplier.
// Directed vector table, multi-cycle corner sequences and randomized frames against a frame-level model.
module tb_mac_accum_6bit;

   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [ND-1:0]  in_valid, in_ready, out_valid, out_ready, ovf;
   logic [5:0]     a_in [ND];
   logic [5:0]     b_in [ND];
   logic [5:0]     ma   [ND];
   logic [5:0]     mb   [ND];
   logic [11:0]    mp   [ND];
   logic [15:0]    acc0;
   logic [11:0]    acc1, acc2;

   int n_checks = 0;
   int n_fail   = 0;

   always_comb begin
      for (int i = 0; i < ND; i++)
         mp[i] = 12'($signed({{6{ma[i][5]}}, ma[i]}) * $signed({{6{mb[i][5]}}, mb[i]}));
   end

   mac_accum_6bit #(.N_TERMS(4), .ACC_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a_in(a_in[0]), .b_in(b_in[0]), .mult_a(ma[0]), .mult_b(mb[0]), .mult_p(mp[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .acc_out(acc0), .ovf(ovf[0]));

   mac_accum_6bit #(.N_TERMS(2), .ACC_W(12)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a_in(a_in[1]), .b_in(b_in[1]), .mult_a(ma[1]), .mult_b(mb[1]), .mult_p(mp[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .acc_out(acc1), .ovf(ovf[1]));

   mac_accum_6bit #(.N_TERMS(3), .ACC_W(12)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a_in(a_in[2]), .b_in(b_in[2]), .mult_a(ma[2]), .mult_b(mb[2]), .mult_p(mp[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .acc_out(acc2), .ovf(ovf[2]));

   typedef struct {
      string           name;
      int              d;
      logic [3:0][5:0] a;
      logic [3:0][5:0] b;
      int              exp_acc;
      int              exp_ovf;
   } vec_t;

   vec_t vecs[7];

   function automatic int nterms(int d);
      case (d)
         0: return 4;
         1: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int accw(int d);
      return (d == 0) ? 16 : 12;
   endfunction

   function automatic int get_acc(int d);
      case (d)
         0: return int'($signed(acc0));
         1: return int'($signed(acc1));
         default: return int'($signed(acc2));
      endcase
   endfunction

   function automatic vec_t mk(string nm, int d, int a0, int b0, int a1, int b1,
                               int a2, int b2, int a3, int b3, int ea, int eo);
      vec_t v;
      v.name = nm; v.d = d;
      v.a[0] = a0[5:0]; v.b[0] = b0[5:0];
      v.a[1] = a1[5:0]; v.b[1] = b1[5:0];
      v.a[2] = a2[5:0]; v.b[2] = b2[5:0];
      v.a[3] = a3[5:0]; v.b[3] = b3[5:0];
      v.exp_acc = ea; v.exp_ovf = eo;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT, expected handshake", name);
   endtask

   task automatic send(int d, int a, int b);
      int cyc;
      @(negedge clk);
      in_valid[d] = 1'b1;
      a_in[d] = a[5:0];
      b_in[d] = b[5:0];
      cyc = 0;
      while (!in_ready[d] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready[d]) timeout("send");
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_out(int d, output int lat);
      lat = 0;
      @(negedge clk);
      while (!out_valid[d] && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      if (!out_valid[d]) timeout("wait_out");
   endtask

   task automatic mstep(int d, int a, int b, inout int acc, inout int ov);
      int s, hi, lo;
      hi = (1 << (accw(d) - 1)) - 1;
      lo = -(1 << (accw(d) - 1));
      s = acc + a * b;
      if (s > hi) begin s = hi; ov = 1; end
      else if (s < lo) begin s = lo; ov = 1; end
      acc = s;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      for (int i = 0; i < ND; i++) begin a_in[i] = '0; b_in[i] = '0; end

      vecs[0] = mk("frame_basic", 0,   3,   5,  -2,   7,  31,  31, -32, -32,  1986, 0);
      vecs[1] = mk("sat_pos",     1, -32, -32, -32, -32,   0,   0,   0,   0,  2047, 1);
      vecs[2] = mk("sat_neg",     2, -32,  31, -32,  31, -32,  31,   0,   0, -2048, 1);
      vecs[3] = mk("off_rail",    2, -32, -32, -32, -32, -32,  31,   0,   0,  1055, 1);
      vecs[4] = mk("neg_frame",   0, -32,  31, -32,  31, -32,  31, -32,  31, -3968, 0);
      vecs[5] = mk("mixed",       1,  31, -32,  31,  31,   0,   0,   0,   0,   -31, 0);
      vecs[6] = mk("zeros",       0,   0,  17,  -5,   0,   0,   0,   0, -32,     0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         check("rst_in_ready",  int'(in_ready[d]),  1);
         check("rst_out_valid", int'(out_valid[d]), 0);
         check("rst_acc",       get_acc(d),         0);
         check("rst_ovf",       int'(ovf[d]),       0);
         check("rst_mult_a",    int'(ma[d]),        0);
         check("rst_mult_b",    int'(mb[d]),        0);
      end

      // Directed frame table
      out_ready = '1;
      for (int v = 0; v < 7; v++) begin
         for (int j = 0; j < nterms(vecs[v].d); j++)
            send(vecs[v].d, int'($signed(vecs[v].a[j])), int'($signed(vecs[v].b[j])));
         wait_out(vecs[v].d, lat);
         check({vecs[v].name, "_latency"}, lat, 1);
         check({vecs[v].name, "_acc"}, get_acc(vecs[v].d), vecs[v].exp_acc);
         check({vecs[v].name, "_ovf"}, int'(ovf[vecs[v].d]), vecs[v].exp_ovf);
         @(negedge clk);
         check({vecs[v].name, "_valid_1cyc"}, int'(out_valid[vecs[v].d]), 0);
         check({vecs[v].name, "_acc_clr"}, get_acc(vecs[v].d), 0);
         check({vecs[v].name, "_ovf_clr"}, int'(ovf[vecs[v].d]), 0);
         check({vecs[v].name, "_load"}, int'(in_ready[vecs[v].d]), 1);
      end
      out_ready = '0;

      // Backpressure: outputs frozen, new operands ignored
      for (int j = 0; j < 4; j++) send(0, 1, 2);
      wait_out(0, lat);
      in_valid[0] = 1'b1;
      a_in[0] = 6'd7;
      b_in[0] = 6'd9;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",    int'(out_valid[0]), 1);
         check("bp_acc",      get_acc(0),         8);
         check("bp_ovf",      int'(ovf[0]),       0);
         check("bp_in_ready", int'(in_ready[0]),  0);
         check("bp_mult_a",   int'(ma[0]),        1);
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      check("bp_rel_valid", int'(out_valid[0]), 0);
      check("bp_rel_acc",   get_acc(0),         0);
      check("bp_rel_load",  int'(in_ready[0]),  1);
      out_ready[0] = 1'b0;

      // Sticky ovf held under backpressure
      for (int j = 0; j < 2; j++) send(1, -32, -32);
      wait_out(1, lat);
      for (int i = 0; i < 3; i++) begin
         check("bp_sat_ovf", int'(ovf[1]), 1);
         check("bp_sat_acc", get_acc(1),   2047);
         @(negedge clk);
      end
      out_ready[1] = 1'b1;
      @(negedge clk);
      check("bp_sat_clr", int'(ovf[1]), 0);
      out_ready[1] = 1'b0;

      // Reset mid-frame discards partial sum
      send(0, 5, 5);
      send(0, 5, 5);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_acc",   get_acc(0),        0);
      check("midrst_ready", int'(in_ready[0]), 1);
      out_ready[0] = 1'b1;
      for (int j = 0; j < 4; j++) send(0, 1, 1);
      wait_out(0, lat);
      check("midrst_frame", get_acc(0), 4);
      @(negedge clk);
      out_ready[0] = 1'b0;

      // rst together with out_ready: reset clears the operand registers too
      for (int j = 0; j < 4; j++) send(0, 2, 3);
      wait_out(0, lat);
      check("rstrdy_pre", get_acc(0), 24);
      out_ready[0] = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready[0] = 1'b0;
      @(negedge clk);
      check("rstrdy_mult_a", int'(ma[0]),        0);
      check("rstrdy_valid",  int'(out_valid[0]), 0);
      check("rstrdy_acc",    get_acc(0),         0);

      // Continuous in_valid: in_ready alternates, out_valid follows the 4th MUL
      @(negedge clk);
      in_valid[0] = 1'b1;
      a_in[0] = 6'd3;
      b_in[0] = 6'b111100;
      for (int i = 0; i < 8; i++) begin
         check("cont_in_ready", int'(in_ready[0]),  (i % 2 == 0) ? 1 : 0);
         check("cont_no_valid", int'(out_valid[0]), 0);
         if (i == 1) check("cont_mult_a", int'(ma[0]), 3);
         @(negedge clk);
      end
      check("cont_valid", int'(out_valid[0]), 1);
      check("cont_busy",  int'(in_ready[0]),  0);
      check("cont_acc",   get_acc(0),         -48);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      check("cont_drain", int'(out_valid[0]), 0);
      out_ready[0] = 1'b0;

      // Randomized frames against the frame-level model
      for (int d = 0; d < 2; d++) begin
         for (int f = 0; f < 30; f++) begin
            int macc, mov, a, b, hold;
            macc = 0;
            mov = 0;
            for (int j = 0; j < nterms(d); j++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               a = int'($urandom_range(0, 63)) - 32;
               b = int'($urandom_range(0, 63)) - 32;
               mstep(d, a, b, macc, mov);
               send(d, a, b);
            end
            wait_out(d, lat);
            check("rnd_acc", get_acc(d),    macc);
            check("rnd_ovf", int'(ovf[d]),  mov);
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               check("rnd_hold_valid", int'(out_valid[d]), 1);
               check("rnd_hold_acc",   get_acc(d),         macc);
            end
            out_ready[d] = 1'b1;
            @(negedge clk);
            check("rnd_release", int'(out_valid[d]), 0);
            check("rnd_clr",     get_acc(d),         0);
            out_ready[d] = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
